prog_loader: RTL and testbench
==============================

# prog_loader

Boot/run sequencer for the multi-cycle CPU. It accepts a program as a stream of 32-bit instruction words from a host and writes them into instruction memory with an auto-incrementing address. It holds the CPU in reset while loading, then releases reset and pulses start. It watches for halt or a watchdog timeout and reports completion, replacing hand-driven load/ins/start sequencing.

## Interface
Parameters:
- ADDR_W, 7, instruction-memory address width; capacity = 2**ADDR_W words
- ARM_CYCLES, 2, cycles `cpu_rst` stays high in ARM before release
- WDOG_W, 16, watchdog counter width; timeout after 2**WDOG_W − 1 RUN cycles

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- load_req  in  1  pulse: start a new load (clears length and errors)
- run_req  in  1  pulse: re-run the loaded program from DONE
- abort  in  1  pulse: return to IDLE from any state
- host_valid  in  1  host word valid
- host_data  in  32  instruction word
- host_last  in  1  marks the final word of the program
- host_ready  out  1  loader accepts a word this cycle
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  write data
- cpu_rst  out  1  CPU reset, active-high
- cpu_start  out  1  one-cycle start pulse
- cpu_halt  in  1  CPU has finished
- busy  out  1  state ≠ IDLE and ≠ DONE
- done  out  1  high in DONE
- prog_len  out  ADDR_W+1  words stored
- err_overflow  out  1  sticky: more words than capacity were offered
- err_timeout  out  1  sticky: watchdog expired in RUN

## Operation
- States: IDLE, LOAD, ARM, RUN, DONE.
- IDLE: `cpu_rst`=1, `host_ready`=0. On `load_req`, go to LOAD with `prog_len`=0, errors cleared, and address counter 0. `run_req` is ignored.
- LOAD: `host_ready`=1, `cpu_rst`=1.
  - Beat = `host_valid && host_ready`.
  - If `prog_len` < 2**ADDR_W, the word is written and `prog_len` increments.
  - Otherwise the word is discarded and `err_overflow` is set.
  - A beat with `host_last` goes to ARM, whether or not the word was stored.
- ARM: `cpu_rst` held for ARM_CYCLES cycles, then dropped. On the next cycle `cpu_start` pulses once and the FSM enters RUN. The watchdog is cleared on entering RUN.
- RUN: `cpu_halt` goes to DONE. Watchdog reaching max sets `err_timeout` and goes to DONE with `cpu_rst` reasserted. If both occur in the same cycle, halt wins and no error is set.
- DONE: `done`=1; the CPU is left in its halted state. `load_req` goes to LOAD (cleared as above). `run_req` goes to ARM with `cpu_rst` reasserted, `prog_len` kept, errors cleared.
- Priority when pulses coincide: abort > load_req > run_req.
- abort in any state: go to IDLE next cycle, `cpu_rst`=1, drop any in-flight beat. `prog_len` and error flags are kept.
- `load_req` in LOAD/ARM/RUN is ignored; abort first.

## Timing
- Reset values: `cpu_rst`=1; all other outputs 0; state IDLE.
- Write latency: a beat accepted at edge N produces `imem_we`=1 with the registered address/data during cycle N+1. `imem_addr` equals the word index (0-based).
- `host_ready` is a registered function of state (no combinational path from `host_valid`). It is 0 in the cycle after the `host_last` beat.
- Start latency: the `host_last` beat is accepted at edge N. `cpu_rst` is high through cycle N+ARM_CYCLES and low from N+ARM_CYCLES+1. `cpu_start`=1 exactly in cycle N+ARM_CYCLES+1.
- `done` rises one cycle after the halt or timeout edge.
- Reset mid-operation clears everything immediately, asynchronously; partially written memory is not scrubbed.

## Structure
- Package `prog_loader_pkg`: state enum (IDLE, LOAD, ARM, RUN, DONE) and default parameter constants.
- One sub-module, `ldr_watchdog`: WDOG_W-bit counter with clear and enable inputs and an `expired` output. It also serves as the ARM-cycle counter via a separate terminal-count compare in the parent.
- FSM, address counter and error flags live in `prog_loader`.

## Test plan
- Load 5 words (0x01308093, 0x00002103, 0x003101B3, 0x00100013, 0xFE101DE3 with `host_last` on word 4) → `imem_we` at addrs 0..4 with matching data, `prog_len`=5, `cpu_start` pulse 3 cycles after the last beat (ARM_CYCLES=2).
- After start, assert `cpu_halt` 10 cycles later → `done`=1 next cycle, `busy`=0, no errors; then `run_req` → `cpu_rst` high 2 cycles, `cpu_start` pulse, `prog_len` still 5.
- ADDR_W=2, offer 6 words with `host_last` on the 6th → only 4 writes (addrs 0..3), `prog_len`=4, `err_overflow`=1, FSM reaches ARM.
- WDOG_W=4, no halt → `err_timeout`=1 and DONE after 15 RUN cycles, `cpu_rst`=1; `cpu_halt` coincident with expiry → no error.
- `abort` during LOAD after 2 words with `host_valid` held → IDLE, no further `imem_we`, `host_ready`=0, `cpu_rst`=1.
- Assert `rst` while in RUN → all outputs return to reset values asynchronously; `load_req` and `run_req` in the same DONE cycle → LOAD taken.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and default sizing for the program loader / boot sequencer.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ARM,
      ST_RUN,
      ST_DONE
   } state_e;

   localparam int unsigned DEF_ADDR_W     = 7;
   localparam int unsigned DEF_ARM_CYCLES = 2;
   localparam int unsigned DEF_WDOG_W     = 16;

endpackage

// File: rtl/ldr_watchdog.sv
// Free-running cycle counter with synchronous clear; doubles as the ARM-phase
// counter and the RUN-phase watchdog.
module ldr_watchdog #(
   parameter int unsigned WDOG_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   output logic [WDOG_W-1:0] count_o,
   output logic              expired_o
);

   logic [WDOG_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;
   // Fires on the enabled cycle whose increment lands on all-ones, so the
   // window is exactly 2**WDOG_W-1 enabled cycles long.
   assign expired_o = en_i && (cnt_q == ~WDOG_W'(1));

endmodule

// File: rtl/prog_loader.sv
// Boot/run sequencer: streams host words into instruction memory, sequences
// CPU reset/start, and watches for halt or watchdog timeout.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned ARM_CYCLES = DEF_ARM_CYCLES,
   parameter int unsigned WDOG_W     = DEF_WDOG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic              run_req,
   input  logic              abort,
   input  logic              host_valid,
   input  logic [31:0]       host_data,
   input  logic              host_last,
   output logic              host_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              cpu_start,
   input  logic              cpu_halt,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   prog_len,
   output logic              err_overflow,
   output logic              err_timeout
);

   localparam logic [WDOG_W-1:0] ARM_TC = WDOG_W'(ARM_CYCLES - 1);

   state_e              state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic                ovf_q, ovf_d;
   logic                tmo_q, tmo_d;
   logic                crst_q, crst_d;
   logic                start_q, start_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;

   logic                beat;
   logic                full;
   logic                wd_clr, wd_en, wd_exp;
   logic [WDOG_W-1:0]   wd_cnt;

   ldr_watchdog #(.WDOG_W(WDOG_W)) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .count_o   (wd_cnt),
      .expired_o (wd_exp)
   );

   assign beat   = (state_q == ST_LOAD) && host_valid && !abort;
   assign full   = len_q[ADDR_W];
   // Restart the count on every state change so ARM and RUN each begin at 0.
   assign wd_clr = (state_d != state_q);
   assign wd_en  = (state_q == ST_ARM) || (state_q == ST_RUN);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      tmo_d   = tmo_q;
      crst_d  = crst_q;
      start_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (abort) begin
         state_d = ST_IDLE;
         crst_d  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               crst_d = 1'b1;
               if (load_req) begin
                  state_d = ST_LOAD;
                  len_d   = '0;
                  ovf_d   = 1'b0;
                  tmo_d   = 1'b0;
               end
            end
            ST_LOAD: begin
               crst_d = 1'b1;
               if (beat) begin
                  if (!full) begin
                     we_d    = 1'b1;
                     addr_d  = len_q[ADDR_W-1:0];
                     wdata_d = host_data;
                     len_d   = len_q + 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  if (host_last) state_d = ST_ARM;
               end
            end
            ST_ARM: begin
               crst_d = 1'b1;
               if (wd_cnt == ARM_TC) begin
                  state_d = ST_RUN;
                  crst_d  = 1'b0;
                  start_d = 1'b1;
               end
            end
            ST_RUN: begin
               if (cpu_halt) begin
                  state_d = ST_DONE;
               end else if (wd_exp) begin
                  state_d = ST_DONE;
                  tmo_d   = 1'b1;
                  crst_d  = 1'b1;
               end
            end
            ST_DONE: begin
               if (load_req) begin
                  state_d = ST_LOAD;
                  len_d   = '0;
                  ovf_d   = 1'b0;
                  tmo_d   = 1'b0;
                  crst_d  = 1'b1;
               end else if (run_req) begin
                  state_d = ST_ARM;
                  ovf_d   = 1'b0;
                  tmo_d   = 1'b0;
                  crst_d  = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               crst_d  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
         crst_q  <= 1'b1;
         start_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
         crst_q  <= crst_d;
         start_q <= start_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign host_ready   = (state_q == ST_LOAD);
   assign busy         = (state_q == ST_LOAD) || (state_q == ST_ARM) || (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign cpu_rst      = crst_q;
   assign cpu_start    = start_q;
   assign prog_len     = len_q;
   assign err_overflow = ovf_q;
   assign err_timeout  = tmo_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench: two loaders (large and 4-word memory) share one stimulus;
// a negedge monitor scores memory writes against queued expectations.
module tb_prog_loader;

   localparam int unsigned AW0 = 7;
   localparam int unsigned AW1 = 2;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load_req = 1'b0, run_req = 1'b0, abort = 1'b0;
   logic host_valid = 1'b0, host_last = 1'b0, cpu_halt = 1'b0;
   logic [31:0] host_data = '0;

   logic            rdy0, we0, crst0, start0, busy0, done0, ovf0, tmo0;
   logic [AW0-1:0]  addr0;
   logic [31:0]     wd0;
   logic [AW0:0]    len0;
   logic            rdy1, we1, crst1, start1, busy1, done1, ovf1, tmo1;
   logic [AW1-1:0]  addr1;
   logic [31:0]     wd1;
   logic [AW1:0]    len1;

   int errors = 0;
   int checks = 0;
   wr_t q0[$];
   wr_t q1[$];
   logic [31:0] prog[5] = '{32'h01308093, 32'h00002103, 32'h003101B3,
                            32'h00100013, 32'hFE101DE3};

   always #5 clk = ~clk;

   prog_loader #(.ADDR_W(AW0), .ARM_CYCLES(2), .WDOG_W(4)) dut0 (
      .clk(clk), .rst(rst), .load_req(load_req), .run_req(run_req), .abort(abort),
      .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
      .host_ready(rdy0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
      .cpu_rst(crst0), .cpu_start(start0), .cpu_halt(cpu_halt), .busy(busy0),
      .done(done0), .prog_len(len0), .err_overflow(ovf0), .err_timeout(tmo0));

   prog_loader #(.ADDR_W(AW1), .ARM_CYCLES(2), .WDOG_W(4)) dut1 (
      .clk(clk), .rst(rst), .load_req(load_req), .run_req(run_req), .abort(abort),
      .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
      .host_ready(rdy1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
      .cpu_rst(crst1), .cpu_start(start1), .cpu_halt(cpu_halt), .busy(busy1),
      .done(done1), .prog_len(len1), .err_overflow(ovf1), .err_timeout(tmo1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input int unsigned a, input logic [31:0] d, input bit both);
      wr_t w;
      w.addr = a;
      w.data = d;
      q0.push_back(w);
      if (both) q1.push_back(w);
   endtask

   // Score memory writes for both DUTs.
   always @(negedge clk) begin
      wr_t w;
      if (we0) begin
         if (q0.size() == 0) chk("dut0 unexpected imem_we", 32'd1, 32'd0);
         else begin
            w = q0.pop_front();
            chk("dut0 imem_addr", 32'(addr0), w.addr);
            chk("dut0 imem_wdata", wd0, w.data);
         end
      end
      if (we1) begin
         if (q1.size() == 0) chk("dut1 unexpected imem_we", 32'd1, 32'd0);
         else begin
            w = q1.pop_front();
            chk("dut1 imem_addr", 32'(addr1), w.addr);
            chk("dut1 imem_wdata", wd1, w.data);
         end
      end
   end

   initial begin
      // Reset values
      tick(3);
      chk("rst cpu_rst", 32'(crst0), 1);
      chk("rst host_ready", 32'(rdy0), 0);
      chk("rst busy/done", {30'd0, busy0, done0}, 0);
      chk("rst start/we", {30'd0, start0, we0}, 0);
      chk("rst prog_len", 32'(len0), 0);
      chk("rst errors", {30'd0, ovf0, tmo0}, 0);
      rst = 1'b0;
      tick();

      // run_req ignored in IDLE
      run_req = 1'b1; tick(); run_req = 1'b0;
      chk("idle ignores run_req busy", 32'(busy0), 0);

      // Five-word load; dut1 holds four and drops the last word
      load_req = 1'b1; tick(); load_req = 1'b0;
      chk("load host_ready", 32'(rdy0), 1);
      chk("load busy", 32'(busy0), 1);
      for (int i = 0; i < 5; i++) begin
         expect_wr(i, prog[i], i < 4);
         host_valid = 1'b1; host_data = prog[i]; host_last = (i == 4);
         tick();
      end
      host_valid = 1'b0; host_last = 1'b0;
      chk("after last host_ready", 32'(rdy0), 0);
      chk("arm1 cpu_rst", 32'(crst0), 1);
      chk("prog_len0", 32'(len0), 5);
      chk("prog_len1", 32'(len1), 4);
      chk("ovf0", 32'(ovf0), 0);
      chk("ovf1", 32'(ovf1), 1);
      chk("dut1 reached ARM busy", 32'(busy1 && !rdy1), 1);
      tick();
      chk("arm2 cpu_rst", 32'(crst0), 1);
      chk("arm2 cpu_start", 32'(start0), 0);
      tick();
      chk("start cpu_rst", 32'(crst0), 0);
      chk("start pulse0", 32'(start0), 1);
      chk("start pulse1", 32'(start1), 1);
      tick();
      chk("start one cycle", 32'(start0), 0);

      // Halt 10 cycles after start
      tick(9);
      cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
      chk("halt done", 32'(done0), 1);
      chk("halt busy", 32'(busy0), 0);
      chk("halt no timeout", 32'(tmo0), 0);
      chk("halt cpu_rst low", 32'(crst0), 0);

      // Re-run from DONE
      run_req = 1'b1; tick(); run_req = 1'b0;
      chk("rerun arm1 cpu_rst", 32'(crst0), 1);
      chk("rerun clears ovf1", 32'(ovf1), 0);
      tick();
      chk("rerun arm2 cpu_rst", 32'(crst0), 1);
      tick();
      chk("rerun start", {30'd0, start0, crst0}, 32'b10);
      chk("rerun prog_len", 32'(len0), 5);

      // Watchdog: 15 RUN cycles then DONE with error
      tick(14);
      chk("wdog cycle15 busy", 32'(busy0), 1);
      chk("wdog cycle15 done", 32'(done0), 0);
      tick();
      chk("wdog done", 32'(done0), 1);
      chk("wdog err_timeout", 32'(tmo0), 1);
      chk("wdog cpu_rst", 32'(crst0), 1);

      // Halt coincident with expiry wins
      run_req = 1'b1; tick(); run_req = 1'b0;
      tick(2);
      chk("run3 start", 32'(start0), 1);
      tick(14);
      cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
      chk("coincident done", 32'(done0), 1);
      chk("coincident no timeout", 32'(tmo0), 0);
      chk("coincident cpu_rst", 32'(crst0), 0);

      // load_req beats run_req in DONE
      load_req = 1'b1; run_req = 1'b1; tick(); load_req = 1'b0; run_req = 1'b0;
      chk("load wins ready", 32'(rdy0), 1);
      chk("load wins prog_len", 32'(len0), 0);
      chk("load wins cpu_rst", 32'(crst0), 1);

      // Abort after two words with host_valid held
      for (int i = 0; i < 2; i++) begin
         expect_wr(i, 32'hA000_0000 + i, 1'b1);
         host_valid = 1'b1; host_data = 32'hA000_0000 + i;
         tick();
      end
      host_data = 32'hDEAD_BEEF;
      abort = 1'b1; tick(); abort = 1'b0;
      tick(3);
      host_valid = 1'b0;
      chk("abort host_ready", 32'(rdy0), 0);
      chk("abort cpu_rst", 32'(crst0), 1);
      chk("abort busy", 32'(busy0), 0);
      chk("abort keeps prog_len", 32'(len0), 2);

      // Six words into the 4-word DUT
      load_req = 1'b1; tick(); load_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         expect_wr(i, 32'hB000_0000 + i, i < 4);
         host_valid = 1'b1; host_data = 32'hB000_0000 + i; host_last = (i == 5);
         tick();
      end
      host_valid = 1'b0; host_last = 1'b0;
      chk("ovf6 prog_len1", 32'(len1), 4);
      chk("ovf6 err1", 32'(ovf1), 1);
      chk("ovf6 prog_len0", 32'(len0), 6);
      chk("ovf6 ARM1", {29'd0, busy1, rdy1, crst1}, 32'b101);

      // Asynchronous reset mid-RUN
      tick(2);
      chk("pre-reset start", 32'(start0), 1);
      #2 rst = 1'b1;
      #1;
      chk("async cpu_rst", 32'(crst0), 1);
      chk("async start/busy", {30'd0, start0, busy0}, 0);
      chk("async prog_len", 32'(len0), 0);
      chk("async ovf1", 32'(ovf1), 0);
      tick();
      rst = 1'b0;
      tick(2);

      chk("dut0 writes outstanding", q0.size(), 0);
      chk("dut1 writes outstanding", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
